// File: rtl/set_button_ctrl.sv
// set_button_ctrl: synchronized, debounced up/down buttons -> inc/dec levels plus a one-cycle step strobe.
// Auto-repeat while a button is held is compiled in with `define SET_BUTTON_REPEAT_EN.
module set_button_ctrl #(
  parameter int DEBOUNCE_CYC  = 250000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_dn,
  output logic inc,
  output logic dec,
  output logic onceler
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
  typedef enum logic [2:0] {LOCK, IDLE, FIRST, HOLD, BOTH} state_e;
  state_e state_q, state_d;
  logic [1:0] s1_q, s2_q, acc_q;
  logic [DW-1:0] db_q [2];
  logic armed_q, held_q, held_d, once_d, fire, up, dn;
  assign up = acc_q[0];
  assign dn = acc_q[1];
  // bit 0 = up, bit 1 = down; a bounce back to the accepted level clears the count
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      acc_q <= '0;
      db_q <= '{default: '0};
    end else begin
      s1_q <= {btn_dn, btn_up};
      s2_q <= s1_q;
      for (int k = 0; k < 2; k++) begin
        acc_q[k] <= (db_q[k] == DB_LAST) ? s2_q[k] : acc_q[k];
        db_q[k] <= (s2_q[k] == acc_q[k] || db_q[k] == DB_LAST) ? '0 : db_q[k] + 1'b1;
      end
    end
  end
  // armed_q holds LOCK one extra cycle so a button held through reset reaches s1 first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOCK;
      held_q <= 1'b0;
      armed_q <= 1'b0;
      inc <= 1'b0;
      dec <= 1'b0;
      onceler <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q <= held_d;
      armed_q <= 1'b1;
      inc <= up & ~dn & (state_q != BOTH);
      dec <= dn & ~up & (state_q != BOTH);
      onceler <= once_d;
    end
  end
  always_comb begin
    state_d = state_q;
    held_d = held_q;
    once_d = 1'b0;
    case (state_q)
      LOCK: state_d = (armed_q && ~|{acc_q, s1_q, s2_q}) ? IDLE : LOCK;
      IDLE: begin
        state_d = (up & dn) ? BOTH : (up | dn) ? FIRST : IDLE;
        once_d = up ^ dn;
        held_d = (up ^ dn) ? dn : held_q;
      end
      FIRST: state_d = HOLD;
      HOLD: begin
        state_d = (held_q ? up : dn) ? BOTH : (held_q ? dn : up) ? HOLD : IDLE;
        once_d = fire & (held_q ? dn & ~up : up & ~dn);
      end
      BOTH: state_d = (up | dn) ? BOTH : IDLE;
      default: state_d = LOCK;
    endcase
  end
`ifdef SET_BUTTON_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  // HOLD starts two cycles after the first strobe, hence the -2 on the initial delay
  localparam logic [RW-1:0] DLY_T = RW'((REPEAT_DELAY > 2) ? REPEAT_DELAY - 2 : 0);
  localparam logic [RW-1:0] PER_T = RW'(REPEAT_PERIOD - 1);
  logic [RW-1:0] rc_q;
  logic rep_q;
  assign fire = (state_q == HOLD) && (rc_q == (rep_q ? PER_T : DLY_T));
  always_ff @(posedge clk) begin
    rc_q <= (rst || state_q != HOLD || fire) ? '0 : (&rc_q) ? rc_q : rc_q + 1'b1;
    rep_q <= (rst || state_q != HOLD) ? 1'b0 : rep_q | fire;
  end
`else
  assign fire = 1'b0;
`endif
endmodule

// File: tb/tb_set_button_ctrl.sv
// tb_set_button_ctrl: randomized and directed checks of set_button_ctrl against a window-based reference model.
module tb_set_button_ctrl;
  localparam int D = 4, RD = 20, RP = 8;
`ifdef SET_BUTTON_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, btn_up = 1'b0, btn_dn = 1'b0;
  logic inc, dec, onceler;
  int checks = 0, errors = 0;
  int n = 16, mode = 0, t0 = 0, lr = 0;
  bit rh_up [8192];
  bit rh_dn [8192];
  bit a_up, a_dn, ex_inc, ex_dec, ex_once, held_dn;

  set_button_ctrl #(.DEBOUNCE_CYC(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
    .inc(inc), .dec(dec), .onceler(onceler)
  );

  always #5 clk = ~clk;

  // accepted level flips once the last D synchronized samples all disagree with it
  function automatic bit settle(input bit sel_up, input bit cur);
    for (int k = n - D - 1; k <= n - 2; k++)
      if ((sel_up ? rh_up[k] : rh_dn[k]) == cur) return cur;
    return !cur;
  endfunction

  // mode: 0 lock, 1 idle, 2 holding (t0 = edge of first strobe), 3 both
  task automatic step();
    bit pu, pd, h, o;
    int dt;
    @(posedge clk);
    n++;
    pu = a_up;
    pd = a_dn;
    if (rst) begin
      rh_up[n] = 0; rh_dn[n] = 0; rh_up[n-1] = 0; rh_dn[n-1] = 0;
      a_up = 0; a_dn = 0; ex_inc = 0; ex_dec = 0; ex_once = 0;
      mode = 0; lr = n;
    end else begin
      rh_up[n] = btn_up;
      rh_dn[n] = btn_dn;
      a_up = settle(1'b1, pu);
      a_dn = settle(1'b0, pd);
      ex_inc = pu & ~pd & (mode != 3);
      ex_dec = pd & ~pu & (mode != 3);
      ex_once = 0;
      dt = n - t0;
      case (mode)
        0: if (n >= lr + 2 && !(pu | pd | rh_up[n-1] | rh_dn[n-1] | rh_up[n-2] | rh_dn[n-2])) mode = 1;
        1: if (pu & pd) mode = 3;
           else if (pu | pd) begin ex_once = 1; held_dn = pd; t0 = n; mode = 2; end
        2: if (dt > 1) begin
             h = held_dn ? pd : pu;
             o = held_dn ? pu : pd;
             if (o) mode = 3;
             else if (!h) mode = 1;
             else if (REP_EN && dt >= RD && (dt - RD) % RP == 0) ex_once = 1;
           end
        3: if (!(pu | pd)) mode = 1;
        default: mode = 0;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) begin
      step();
      checks++;
      if ({inc, dec, onceler} !== 3'b000) begin
        errors++;
        $display("FAIL reset: inc/dec/once=%b required 000", {inc, dec, onceler});
      end
    end
    rst = 0;
    repeat (10) step();
  endtask

  task automatic test_clean_press();
    int p, first = -1, cnt = 0, rel, fall = -1;
    btn_up = 1;
    p = n + 1;
    repeat (20) begin
      step();
      checks++;
      if ({inc, dec, onceler} !== {ex_inc, ex_dec, ex_once}) begin
        errors++;
        $display("FAIL clean_press t=%0d: got %b required %b", n - p, {inc, dec, onceler}, {ex_inc, ex_dec, ex_once});
      end
      if (onceler) begin cnt++; if (first < 0) first = n - p; end
    end
    checks++;
    if (cnt !== 1 || first !== 6) begin
      errors++;
      $display("FAIL clean_press_timing: %0d strobes first at t=%0d, required 1 at t=6", cnt, first);
    end
    btn_up = 0;
    rel = n + 1;
    repeat (12) begin
      step();
      checks++;
      if ({inc, dec, onceler} !== {ex_inc, ex_dec, ex_once}) begin
        errors++;
        $display("FAIL clean_release t=%0d: got %b required %b", n - rel, {inc, dec, onceler}, {ex_inc, ex_dec, ex_once});
      end
      if (fall < 0 && !inc) fall = n - rel;
    end
    checks++;
    if (fall !== 6) begin
      errors++;
      $display("FAIL inc_fall: inc fell at t=%0d required t=6", fall);
    end
  endtask

  task automatic test_bounce();
    int p, bad = 0, first = -1, cnt = 0;
    for (int i = 0; i < 20; i++) begin
      btn_dn = ((i / 2) % 2) == 0;
      step();
      checks++;
      if ({inc, dec, onceler} !== {ex_inc, ex_dec, ex_once}) begin
        errors++;
        $display("FAIL bounce i=%0d: got %b required %b", i, {inc, dec, onceler}, {ex_inc, ex_dec, ex_once});
      end
      if (onceler) bad++;
    end
    btn_dn = 1;
    p = n + 1;
    repeat (14) begin
      step();
      checks++;
      if ({inc, dec, onceler} !== {ex_inc, ex_dec, ex_once}) begin
        errors++;
        $display("FAIL bounce_settle t=%0d: got %b required %b", n - p, {inc, dec, onceler}, {ex_inc, ex_dec, ex_once});
      end
      if (onceler && dec && !inc) begin cnt++; if (first < 0) first = n - p; end
    end
    checks++;
    if (bad !== 0 || cnt !== 1 || first !== 6) begin
      errors++;
      $display("FAIL bounce_timing: %0d during bounce, %0d after first t=%0d, required 0, 1, t=6", bad, cnt, first);
    end
    btn_dn = 0;
    repeat (15) step();
  endtask

  task automatic test_hold_repeat();
    int p, q[$];
    int exp_t[6] = '{6, 26, 34, 42, 50, 58};
    btn_up = 1;
    p = n + 1;
    repeat (60) begin
      step();
      checks++;
      if ({inc, dec, onceler} !== {ex_inc, ex_dec, ex_once}) begin
        errors++;
        $display("FAIL hold t=%0d: got %b required %b", n - p, {inc, dec, onceler}, {ex_inc, ex_dec, ex_once});
      end
      if (onceler) q.push_back(n - p);
    end
    checks++;
    if (q.size() !== (REP_EN ? 6 : 1)) begin
      errors++;
      $display("FAIL hold_count: %0d strobes required %0d", q.size(), REP_EN ? 6 : 1);
    end else
      foreach (q[i]) begin
        checks++;
        if (q[i] !== exp_t[i]) begin
          errors++;
          $display("FAIL hold_time[%0d]: t=%0d required t=%0d", i, q[i], exp_t[i]);
        end
      end
    btn_up = 0;
    repeat (15) step();
  endtask

  task automatic test_both();
    int late = 0;
    for (int t = 0; t < 95; t++) begin
      btn_up = t < 70;
      btn_dn = t >= 30 && t < 50;
      step();
      checks++;
      if ({inc, dec, onceler} !== {ex_inc, ex_dec, ex_once}) begin
        errors++;
        $display("FAIL both t=%0d: got %b required %b", t, {inc, dec, onceler}, {ex_inc, ex_dec, ex_once});
      end
      if (t >= 36 && onceler) late++;
      if ((t == 45 || t == 62) && (inc | dec)) begin
        errors++;
        $display("FAIL both_levels t=%0d: inc=%b dec=%b required 0 0", t, inc, dec);
      end
    end
    checks++;
    if (late !== 0) begin
      errors++;
      $display("FAIL both_strobes: %0d strobes after both pressed, required 0", late);
    end
  endtask

  task automatic test_reset_hold();
    int cnt = 0, first = -1, held_cnt = 0;
    for (int t = 0; t < 88; t++) begin
      btn_up = t < 50 || t >= 70;
      rst = t == 15;
      step();
      checks++;
      if ({inc, dec, onceler} !== {ex_inc, ex_dec, ex_once}) begin
        errors++;
        $display("FAIL reset_hold t=%0d: got %b required %b", t, {inc, dec, onceler}, {ex_inc, ex_dec, ex_once});
      end
      if (t == 15 && {inc, dec, onceler} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold_clear: got %b required 000", {inc, dec, onceler});
      end
      if (onceler && t >= 15 && t < 70) held_cnt++;
      if (onceler && t >= 70) begin cnt++; if (first < 0) first = t - 70; end
    end
    rst = 0;
    checks++;
    if (held_cnt !== 0 || cnt !== 1 || first !== 6) begin
      errors++;
      $display("FAIL reset_hold_timing: %0d while locked, %0d after re-press at t=%0d, required 0, 1, t=6", held_cnt, cnt, first);
    end
    btn_up = 0;
    repeat (15) step();
  endtask

  task automatic test_random();
    int len;
    bit r;
    repeat (150) begin
      btn_up = $urandom_range(0, 1);
      btn_dn = $urandom_range(0, 2) == 0;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
      r = $urandom_range(0, 29) == 0;
      for (int k = 0; k < len; k++) begin
        rst = r && k == 0;
        step();
        checks++;
        if ({inc, dec, onceler} !== {ex_inc, ex_dec, ex_once}) begin
          errors++;
          $display("FAIL random n=%0d: got %b required %b", n, {inc, dec, onceler}, {ex_inc, ex_dec, ex_once});
        end
        if (onceler && !(inc ^ dec)) begin
          errors++;
          $display("FAIL random_qualify n=%0d: onceler with inc=%b dec=%b", n, inc, dec);
        end
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_repeat();
    test_both();
    test_reset_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
